// File: rtl/usb_in_arbiter_pkg.sv
// Shared types and helpers for the USB IN-side round-robin arbiter.
package usb_in_arbiter_pkg;

  // Arbiter FSM: IDLE picks a requester, GRANT passes its bytes through.
  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } arb_state_e;

  localparam int unsigned DataW = 8;

  // Counter width for a modulus, never narrower than one bit.
  function automatic int unsigned clog2_min1(int unsigned value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/usb_in_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module usb_in_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PtrW  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PtrW-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_pick,
  output logic             o_any
);

  localparam logic [N_REQ-1:0] One = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [2*N_REQ-1:0] w_dbl;
  logic [2*N_REQ-1:0] w_pick_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [N_REQ-1:0]   w_rot_pick;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  // Doubling the vector makes the wrap work for any N_REQ, power of 2 or not.
  always_comb begin
    w_dbl      = {i_req, i_req} >> i_ptr;
    w_rot      = w_dbl[N_REQ-1:0];
    w_rot_pick = w_rot & (~w_rot + One);
    w_pick_dbl = {{N_REQ{1'b0}}, w_rot_pick} << i_ptr;
    o_pick     = w_pick_dbl[N_REQ-1:0] | w_pick_dbl[2*N_REQ-1:N_REQ];
    o_any      = |i_req;
  end

endmodule

// File: rtl/usb_in_arbiter.sv
// Round-robin arbiter sharing the usb_cdc IN byte stream among N_REQ requesters.
// A grant is held for a whole burst (last, MAX_BURST bytes, or idle timeout).
module usb_in_arbiter
  import usb_in_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic [DataW*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ-1:0]       req_last_i,
  output logic [N_REQ-1:0]       req_ready_o,
  output logic [DataW-1:0]       in_data_o,
  output logic                   in_valid_o,
  input  logic                   in_ready_i,
  output logic [N_REQ-1:0]       grant_o,
  output logic                   busy_o
);

  localparam int unsigned PtrW   = clog2_min1(N_REQ);
  localparam int unsigned BurstW = clog2_min1(MAX_BURST);
  localparam int unsigned IdleW  = clog2_min1(IDLE_TIMEOUT);

  arb_state_e        r_state, w_state_nxt;
  logic [N_REQ-1:0]  r_grant, w_grant_nxt;
  logic [PtrW-1:0]   r_ptr, w_ptr_nxt;
  logic [BurstW-1:0] r_burst_cnt, w_burst_nxt;
  logic [IdleW-1:0]  r_idle_cnt, w_idle_nxt;

  logic [N_REQ-1:0]  w_pick;
  logic              w_any;
  logic [PtrW-1:0]   w_gidx;
  logic [PtrW-1:0]   w_ptr_adv;
  logic [DataW-1:0]  w_data;
  logic              w_valid;
  logic              w_last;
  logic              w_xfer;
  logic              w_release;

  usb_in_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .PtrW  (PtrW)
  ) u_rr_pick (
    .i_req  (req_valid_i),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_any  (w_any)
  );

  // Grant mux driven only by the registered one-hot grant; all zero in IDLE.
  always_comb begin
    w_gidx  = '0;
    w_data  = '0;
    w_valid = 1'b0;
    w_last  = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (r_grant[k]) begin
        w_gidx  = PtrW'(k);
        w_data  = w_data | req_data_i[DataW*k +: DataW];
        w_valid = w_valid | req_valid_i[k];
        w_last  = w_last | req_last_i[k];
      end
    end
  end

  assign in_data_o   = w_data;
  assign in_valid_o  = w_valid;
  assign req_ready_o = r_grant & {N_REQ{in_ready_i}};
  assign grant_o     = r_grant;
  assign busy_o      = (r_state == StGrant);

  assign w_xfer    = w_valid & in_ready_i;
  assign w_ptr_adv = (w_gidx == PtrW'(N_REQ - 1)) ? '0 : w_gidx + PtrW'(1);
  // Timeout only fires with valid low, transfers only with ready high, so a
  // stalled byte can never lose its grant.
  assign w_release = (w_xfer & (w_last | (r_burst_cnt == BurstW'(MAX_BURST - 1)))) |
                     (~w_valid & (r_idle_cnt == IdleW'(IDLE_TIMEOUT - 1)));

  // Next-state logic: arbitrate in IDLE, count bytes and idle cycles in GRANT.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_burst_nxt = r_burst_cnt;
    w_idle_nxt  = r_idle_cnt;
    case (r_state)
      StIdle: begin
        if (w_any) begin
          w_state_nxt = StGrant;
          w_grant_nxt = w_pick;
          w_burst_nxt = '0;
          w_idle_nxt  = '0;
        end
      end
      StGrant: begin
        if (w_xfer) w_burst_nxt = r_burst_cnt + BurstW'(1);
        w_idle_nxt = w_valid ? '0 : r_idle_cnt + IdleW'(1);
        if (w_release) begin
          w_state_nxt = StIdle;
          w_grant_nxt = '0;
          w_ptr_nxt   = w_ptr_adv;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and counter registers; reset drops any grant immediately.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= StIdle;
      r_grant     <= '0;
      r_ptr       <= '0;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_ptr       <= w_ptr_nxt;
      r_burst_cnt <= w_burst_nxt;
      r_idle_cnt  <= w_idle_nxt;
    end
  end

endmodule

// File: tb/tb_usb_in_arbiter.sv
// Self-checking bench for usb_in_arbiter: fixed vector table, directed bursts,
// then random traffic against a behavioural ownership model.
module tb_usb_in_arbiter;

  localparam int N  = 4;
  localparam int MB = 8;
  localparam int IT = 16;
  localparam int DW = 8 * N;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] req_data = '0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_last = '0;
  logic [N-1:0]  req_ready;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready = 1'b0;
  logic [N-1:0]  grant;
  logic          busy;

  always #5 clk = ~clk;

  usb_in_arbiter #(
    .N_REQ        (N),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (IT)
  ) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .req_data_i  (req_data),
    .req_valid_i (req_valid),
    .req_last_i  (req_last),
    .req_ready_o (req_ready),
    .in_data_o   (in_data),
    .in_valid_o  (in_valid),
    .in_ready_i  (in_ready),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: who owns the stream, where the search starts, how many bytes
  // the owner has moved and how long its valid has been low.
  int m_owner, m_ptr, m_bytes, m_quiet;
  int m_xfer[N];
  int d_xfer[N];

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_bytes = 0; m_quiet = 0;
  endtask

  task automatic model_step();
    bit found, xf;
    if (m_owner < 0) begin
      found = 0;
      for (int i = 0; i < N; i++) begin
        if (!found && req_valid[(m_ptr + i) % N]) begin
          m_owner = (m_ptr + i) % N;
          found = 1;
        end
      end
      m_bytes = 0; m_quiet = 0;
    end else begin
      xf = req_valid[m_owner] && in_ready;
      if (req_valid[m_owner]) m_quiet = 0;
      else m_quiet++;
      if (xf) begin
        m_bytes++;
        m_xfer[m_owner]++;
      end
      if ((xf && (req_last[m_owner] || m_bytes == MB)) || m_quiet == IT) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  // Stimulus sources: burst length (0 = never last), position, bytes left (-1 = endless).
  bit rand_mode = 0;
  int rdy_mode = 0;
  int cyc = 0;
  bit s_en[N];
  int s_len[N], s_pos[N], s_left[N], s_seq[N];

  // Observed grant history.
  int q_order[$];
  int q_len[$];
  int cur_len = 0;
  int quiet1 = 0;
  logic [N-1:0] prev_grant = '0;
  bit stall_prev = 0;
  logic [7:0] data_prev = '0;
  logic [N-1:0] grant_prev = '0;

  task automatic drive_inputs();
    if (rand_mode) begin
      req_valid = N'($urandom);
      req_last  = N'($urandom & $urandom);
      req_data  = DW'($urandom);
      in_ready  = ($urandom_range(0, 3) != 0);
    end else begin
      for (int k = 0; k < N; k++) begin
        req_valid[k] = s_en[k] && (s_left[k] != 0);
        req_last[k]  = (s_len[k] > 0) && (s_pos[k] == s_len[k] - 1);
        req_data[8*k +: 8] = {2'(k), 6'(s_seq[k])};
      end
      case (rdy_mode)
        1: in_ready = (cyc % 2) == 0;
        2: in_ready = $urandom_range(0, 1) == 1;
        default: in_ready = 1'b1;
      endcase
    end
  endtask

  task automatic cycle();
    logic [N-1:0] eg, er, hs;
    logic ev, eb;
    logic [7:0] ed;
    drive_inputs();
    #4;
    if (!rstn) model_reset();
    eg = '0; er = '0; ev = 0; eb = 0; ed = '0;
    if (m_owner >= 0) begin
      eg = N'(1) << m_owner;
      ev = req_valid[m_owner];
      ed = req_data[8*m_owner +: 8];
      er = in_ready ? eg : '0;
      eb = 1;
    end
    check("cycle", {grant, in_valid, in_data, req_ready, busy}, {eg, ev, ed, er, eb});
    if (!rand_mode && stall_prev && grant == grant_prev) check("stall_data", in_data, data_prev);
    stall_prev = in_valid && !in_ready;
    data_prev  = in_data;
    grant_prev = grant;
    hs = req_valid & req_ready;
    for (int k = 0; k < N; k++) if (hs[k]) d_xfer[k]++;
    if (grant == N'(2) && !req_valid[1]) quiet1++;
    if (prev_grant != '0 && grant == '0) q_len.push_back(cur_len);
    if (prev_grant == '0 && grant != '0) begin
      for (int k = 0; k < N; k++) if (grant[k]) q_order.push_back(k);
      cur_len = 0;
    end
    if (grant != '0 && in_valid && in_ready) cur_len++;
    prev_grant = grant;
    @(posedge clk);
    if (rstn) model_step();
    if (!rand_mode) begin
      for (int k = 0; k < N; k++) begin
        if (hs[k]) begin
          s_seq[k]++;
          if (s_len[k] > 0) s_pos[k] = (s_pos[k] + 1) % s_len[k];
          if (s_left[k] > 0) s_left[k]--;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rstn = 0;
    rand_mode = 0;
    rdy_mode = 0;
    for (int k = 0; k < N; k++) begin
      s_en[k] = 0; s_len[k] = 0; s_pos[k] = 0; s_left[k] = -1; s_seq[k] = 0;
    end
    cycle();
    cycle();
    rstn = 1;
    for (int k = 0; k < N; k++) begin
      m_xfer[k] = 0; d_xfer[k] = 0;
    end
    q_order.delete();
    q_len.delete();
    quiet1 = 0;
  endtask

  task automatic check_counts(input string tag);
    for (int k = 0; k < N; k++) check($sformatf("%s_bytes%0d", tag, k), d_xfer[k], m_xfer[k]);
  endtask

  typedef struct {
    logic         rstn;
    logic [N-1:0] valid;
    logic [N-1:0] last;
    logic         rdy;
    logic [N-1:0] e_grant;
    logic         e_valid;
    logic [7:0]   e_data;
    logic [N-1:0] e_ready;
    logic         e_busy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[1] = '{1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[2] = '{1'b1, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 8'hA5, 4'b0100, 1'b1};
    tbl[3] = '{1'b1, 4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[4] = '{1'b1, 4'b0101, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h3C, 4'b0000, 1'b1};
    tbl[5] = '{1'b1, 4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h3C, 4'b0001, 1'b1};
    tbl[6] = '{1'b1, 4'b0101, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[7] = '{1'b1, 4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b0, 8'hA5, 4'b0100, 1'b1};

    model_reset();
    @(posedge clk);
    #1;
    req_data = 32'h44A5_773C;
    for (int i = 0; i < 8; i++) begin
      rstn = tbl[i].rstn;
      req_valid = tbl[i].valid;
      req_last = tbl[i].last;
      in_ready = tbl[i].rdy;
      #4;
      check($sformatf("tbl%0d", i), {grant, in_valid, in_data, req_ready, busy},
            {tbl[i].e_grant, tbl[i].e_valid, tbl[i].e_data, tbl[i].e_ready, tbl[i].e_busy});
      @(posedge clk);
      #1;
    end

    // Fairness: four endless 3-byte bursts.
    do_reset();
    for (int k = 0; k < N; k++) begin
      s_en[k] = 1; s_len[k] = 3;
    end
    run(36);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fair_order%0d", i), (i < q_order.size()) ? q_order[i] : -1, i % N);
      check($sformatf("fair_len%0d", i), (i < q_len.size()) ? q_len[i] : -1, 3);
    end

    // Burst cap: 20 bytes without last from requester 2.
    do_reset();
    s_en[2] = 1; s_left[2] = 20;
    run(70);
    check("cap_grants", q_order.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cap_owner%0d", i), (i < q_order.size()) ? q_order[i] : -1, 2);
      check($sformatf("cap_len%0d", i), (i < q_len.size()) ? q_len[i] : -1, (i == 2) ? 4 : 8);
    end

    // Backpressure: ready toggles while two requesters send 10 bytes each.
    do_reset();
    s_en[0] = 1; s_len[0] = 5; s_left[0] = 10;
    s_en[1] = 1; s_len[1] = 5; s_left[1] = 10;
    rdy_mode = 1;
    run(80);
    check("bp_bytes0", d_xfer[0], 10);
    check("bp_bytes1", d_xfer[1], 10);
    check_counts("bp");

    // Timeout: requester 1 goes quiet after 2 bytes, requester 3 waits.
    do_reset();
    s_en[1] = 1; s_left[1] = 2;
    s_en[3] = 1; s_len[3] = 3; s_left[3] = 3;
    run(30);
    check("to_quiet", quiet1, IT);
    check("to_first", (q_order.size() > 0) ? q_order[0] : -1, 1);
    check("to_next", (q_order.size() > 1) ? q_order[1] : -1, 3);

    // Reset in the middle of an 8-byte burst.
    do_reset();
    s_en[0] = 1; s_len[0] = 8;
    s_en[2] = 1; s_len[2] = 8;
    for (int i = 0; i < 20 && d_xfer[0] < 4; i++) cycle();
    check("mid_pre_bytes", d_xfer[0], 4);
    rstn = 0;
    cycle();
    check("mid_rst_out", {grant, in_valid, req_ready, busy}, '0);
    cycle();
    rstn = 1;
    q_order.delete();
    run(4);
    check("mid_regrant", (q_order.size() > 0) ? q_order[0] : -1, 0);

    // Random traffic against the model.
    do_reset();
    rand_mode = 1;
    run(1500);
    check_counts("rnd");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
